// File: rtl/ncpu32k_dbus_sram_rsp_pkg.sv
// Shared types and bus widths for the dbus SRAM responder.
// Bus widths mirror the core-wide configuration; state encodings are local to this block.
package ncpu32k_dbus_sram_rsp_pkg;

  localparam int NCPU_AW = 32;
  localparam int NCPU_DW = 32;
  localparam int NCPU_BW = NCPU_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } rsp_state_e;

endpackage

// File: rtl/ncpu32k_cell_dff_lr.sv
// Loadable D flip-flop with asynchronous active-low reset to RST_VAL.
// Shared storage cell used for all control state in the core.
module ncpu32k_cell_dff_lr #(
  parameter int            DW      = 1,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ncpu32k_dbus_sram_rsp_array.sv
// Single-port word array with per-byte write enables and a read-first registered output.
// Contents are never reset; only the output register clears so the response word starts at 0.
module ncpu32k_dbus_sram_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [AW-1:0]   addr,
  input  logic [DW/8-1:0] we,
  input  logic [DW-1:0]   din,
  output logic [DW-1:0]   dout
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < DW/8; b++) begin
        if (we[b]) begin
          mem[addr][b*8 +: 8] <= din[b*8 +: 8];
        end
      end
    end
  end

  // Read-first: a store in the same cycle returns the old word, which the top masks to 0 anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (en) begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/ncpu32k_dbus_sram_rsp.sv
// dbus responder backed by a local byte-enabled SRAM; one response beat per accepted cmd.
// NCPU_DBUS_RSP_PERF_EN adds load/store/stall performance counters.
module ncpu32k_dbus_sram_rsp
  import ncpu32k_dbus_sram_rsp_pkg::*;
#(
  parameter int MEM_AW      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               dbus_cmd_valid,
  output logic               dbus_cmd_ready,
  input  logic [NCPU_AW-1:0] dbus_cmd_addr,
  input  logic [NCPU_BW-1:0] dbus_cmd_we_msk,
  input  logic [NCPU_DW-1:0] dbus_din,
  output logic               dbus_valid,
  input  logic               dbus_ready,
  output logic [NCPU_DW-1:0] dbus_dout
`ifdef NCPU_DBUS_RSP_PERF_EN
  ,
  output logic [31:0]        perf_load_cnt,
  output logic [31:0]        perf_store_cnt,
  output logic [31:0]        perf_stall_cnt
`endif
);

  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam rsp_state_e ST_ACCEPT = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;

  logic [1:0]         state_raw_q;
  rsp_state_e         state_q, state_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;
  logic               is_store_q;
  logic [NCPU_DW-1:0] ram_q;
  logic               cmd_hds, rsp_hds, cmd_is_store;
  logic               unused_addr;

  assign state_q        = rsp_state_e'(state_raw_q);
  assign dbus_valid     = (state_q == ST_RESP);
  assign dbus_cmd_ready = (state_q == ST_IDLE) | ((state_q == ST_RESP) & dbus_ready);
  assign cmd_hds        = dbus_cmd_valid & dbus_cmd_ready;
  assign rsp_hds        = dbus_valid & dbus_ready;
  assign cmd_is_store   = |dbus_cmd_we_msk;
  assign dbus_dout      = is_store_q ? '0 : ram_q;
  // Upper bits alias onto the array; sub-word lanes are resolved by the initiator.
  assign unused_addr    = ^{dbus_cmd_addr[NCPU_AW-1:MEM_AW+2], dbus_cmd_addr[1:0]};

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hds) begin
          state_d    = ST_ACCEPT;
          wait_cnt_d = WS_INIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (cmd_hds) begin
          state_d    = ST_ACCEPT;
          wait_cnt_d = WS_INIT;
        end else if (rsp_hds) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  ncpu32k_cell_dff_lr #(.DW(2), .RST_VAL(ST_IDLE)) u_state (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .d(state_d), .q(state_raw_q)
  );

  ncpu32k_cell_dff_lr #(.DW(4)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .load(1'b1), .d(wait_cnt_d), .q(wait_cnt_q)
  );

  ncpu32k_cell_dff_lr #(.DW(1)) u_is_store (
    .clk(clk), .rst_n(rst_n), .load(cmd_hds), .d(cmd_is_store), .q(is_store_q)
  );

  ncpu32k_dbus_sram_array #(.AW(MEM_AW), .DW(NCPU_DW)) u_array (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (cmd_hds),
    .addr (dbus_cmd_addr[MEM_AW+1:2]),
    .we   (dbus_cmd_we_msk),
    .din  (dbus_din),
    .dout (ram_q)
  );

`ifdef NCPU_DBUS_RSP_PERF_EN
  logic [31:0] perf_load_cnt_q, perf_store_cnt_q, perf_stall_cnt_q;
  logic [31:0] perf_load_cnt_d, perf_store_cnt_d, perf_stall_cnt_d;

  always_comb begin
    perf_load_cnt_d  = perf_load_cnt_q + 32'd1;
    perf_store_cnt_d = perf_store_cnt_q + 32'd1;
    perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
  end

  ncpu32k_cell_dff_lr #(.DW(32)) u_perf_load (
    .clk(clk), .rst_n(rst_n), .load(cmd_hds & ~cmd_is_store),
    .d(perf_load_cnt_d), .q(perf_load_cnt_q)
  );
  ncpu32k_cell_dff_lr #(.DW(32)) u_perf_store (
    .clk(clk), .rst_n(rst_n), .load(cmd_hds & cmd_is_store),
    .d(perf_store_cnt_d), .q(perf_store_cnt_q)
  );
  ncpu32k_cell_dff_lr #(.DW(32)) u_perf_stall (
    .clk(clk), .rst_n(rst_n), .load(dbus_valid & ~dbus_ready),
    .d(perf_stall_cnt_d), .q(perf_stall_cnt_q)
  );

  assign perf_load_cnt  = perf_load_cnt_q;
  assign perf_store_cnt = perf_store_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
